removal_pass_scheduler: RTL and testbench

// Sequences repeated neighbour-count sweeps over the roll grid until no more rolls can be removed.

---
 rtl/removal_pass_scheduler.sv | 164 ++++++++++++++++
 tb/tb_removal_pass_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/removal_pass_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// removal_pass_scheduler: streams 3-row windows per pass until no roll is removed
// Revision 1.0
// ----------------------------------------------------------------------------
module removal_pass_scheduler #(
  parameter int WIDTH      = 140,
  parameter int HEIGHT     = 140,
  parameter int ROW_AW     = 8,
  parameter int CNT_W      = 15,
  parameter int MAX_PASSES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  first_pass_o,
  output logic [CNT_W-1:0]  total_removed_o,
  output logic [7:0]        pass_count_o,
  output logic              mem_rd_en_o,
  output logic [ROW_AW-1:0] mem_rd_addr_o,
  input  logic [WIDTH-1:0]  mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [ROW_AW-1:0] mem_wr_addr_o,
  output logic [WIDTH-1:0]  mem_wr_data_o,
  output logic              dp_valid_o,
  output logic [ROW_AW-1:0] dp_row_idx_o,
  output logic [WIDTH-1:0]  dp_row_n_o,
  output logic [WIDTH-1:0]  dp_row_c_o,
  output logic [WIDTH-1:0]  dp_row_s_o,
  input  logic              dp_out_valid_i,
  input  logic [ROW_AW-1:0] dp_out_idx_i,
  input  logic [WIDTH-1:0]  dp_out_row_i,
  input  logic [7:0]        dp_out_cnt_i
);

  localparam int                PTR_W        = ROW_AW + 1;
  localparam logic [PTR_W-1:0]  c_HEIGHT     = PTR_W'(HEIGHT);
  localparam logic [7:0]        c_MAX_PASSES = 8'(MAX_PASSES);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_SWEEP = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_CHECK = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, win_cnt_q, res_cnt_q;
  logic             rd_vld_q, dp_valid_q;
  logic [ROW_AW-1:0] dp_idx_q;
  logic [WIDTH-1:0] n_q, c_q, s_q;
  logic [CNT_W-1:0] pass_rm_q, first_q, total_q;
  logic [7:0]       pass_cnt_q;

  logic             w_accept, w_res_ok, w_shift, w_in_sweep, w_clear;
  logic [CNT_W:0]   w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_DONE: if (start_i) state_d = c_FETCH;
      c_FETCH:        state_d = c_SWEEP;
      // The pad shift (south = 0) happens in the cycle win_cnt reaches HEIGHT.
      c_SWEEP:        if (win_cnt_q == c_HEIGHT) state_d = c_DRAIN;
      c_DRAIN:        if (res_cnt_q == c_HEIGHT) state_d = c_CHECK;
      c_CHECK: begin
        if ((pass_rm_q == '0) || ((pass_cnt_q + 8'd1) == c_MAX_PASSES)) state_d = c_DONE;
        else                                                           state_d = c_FETCH;
      end
      default:        state_d = c_IDLE;
    endcase
  end

  always_comb begin
    w_in_sweep      = (state_q == c_FETCH) || (state_q == c_SWEEP);
    w_clear         = (state_q == c_IDLE) || (state_q == c_DONE) || (state_q == c_CHECK);
    w_accept        = ((state_q == c_IDLE) || (state_q == c_DONE)) && start_i;
    w_res_ok        = dp_out_valid_i && ((state_q == c_SWEEP) || (state_q == c_DRAIN));
    w_shift         = rd_vld_q || (win_cnt_q == c_HEIGHT);
    w_sum           = {1'b0, total_q} + {1'b0, pass_rm_q};
    busy_o          = (state_q != c_IDLE) && (state_q != c_DONE);
    done_o          = (state_q == c_DONE);
    mem_rd_en_o     = w_in_sweep && (rd_ptr_q < c_HEIGHT);
    mem_rd_addr_o   = mem_rd_en_o ? ROW_AW'(rd_ptr_q) : '0;
    mem_wr_en_o     = w_res_ok;
    mem_wr_addr_o   = w_res_ok ? dp_out_idx_i : '0;
    mem_wr_data_o   = w_res_ok ? dp_out_row_i : '0;
    dp_valid_o      = dp_valid_q;
    dp_row_idx_o    = dp_idx_q;
    dp_row_n_o      = n_q;
    dp_row_c_o      = c_q;
    dp_row_s_o      = s_q;
    first_pass_o    = first_q;
    total_removed_o = total_q;
    pass_count_o    = pass_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      win_cnt_q  <= '0;
      res_cnt_q  <= '0;
      rd_vld_q   <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_idx_q   <= '0;
      n_q        <= '0;
      c_q        <= '0;
      s_q        <= '0;
      pass_rm_q  <= '0;
      first_q    <= '0;
      total_q    <= '0;
      pass_cnt_q <= '0;
    end else begin
      rd_vld_q   <= mem_rd_en_o;
      dp_valid_q <= 1'b0;
      if (mem_rd_en_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_in_sweep) begin
        if (w_shift) begin
          n_q       <= c_q;
          c_q       <= s_q;
          s_q       <= rd_vld_q ? mem_rd_data_i : '0;
          win_cnt_q <= win_cnt_q + 1'b1;
          // Centre holds a real row once two shifts have happened.
          if (win_cnt_q != '0) begin
            dp_valid_q <= 1'b1;
            dp_idx_q   <= ROW_AW'(win_cnt_q - 1'b1);
          end
        end
      end else if (w_clear) begin
        n_q       <= '0;
        c_q       <= '0;
        s_q       <= '0;
        rd_ptr_q  <= '0;
        win_cnt_q <= '0;
        res_cnt_q <= '0;
      end
      if (w_res_ok) begin
        res_cnt_q <= res_cnt_q + 1'b1;
        pass_rm_q <= pass_rm_q + CNT_W'(dp_out_cnt_i);
      end
      if (w_accept) begin
        first_q    <= '0;
        total_q    <= '0;
        pass_cnt_q <= '0;
        pass_rm_q  <= '0;
      end
      if (state_q == c_CHECK) begin
        pass_cnt_q <= pass_cnt_q + 8'd1;
        total_q    <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        if (pass_cnt_q == 8'd0) first_q <= pass_rm_q;
        pass_rm_q  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_removal_pass_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_removal_pass_scheduler: random grids vs. a whole-grid pass model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_removal_pass_scheduler;

  localparam int WA = 8;
  localparam int HA = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT A: 8x6 grid, full pass limit
  logic start_a, busy_a, done_a, rd_en_a, wr_en_a, dpv_a, dov_a;
  logic [14:0] first_a, total_a;
  logic [7:0]  pc_a, dcnt_a;
  logic [2:0]  rd_addr_a, wr_addr_a, idx_a, doi_a;
  logic [7:0]  rd_data_a, wr_data_a, n_a, c_a, s_a, dor_a;

  removal_pass_scheduler #(.WIDTH(WA), .HEIGHT(HA), .ROW_AW(3), .CNT_W(15), .MAX_PASSES(255)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .first_pass_o(first_a), .total_removed_o(total_a), .pass_count_o(pc_a),
    .mem_rd_en_o(rd_en_a), .mem_rd_addr_o(rd_addr_a), .mem_rd_data_i(rd_data_a),
    .mem_wr_en_o(wr_en_a), .mem_wr_addr_o(wr_addr_a), .mem_wr_data_o(wr_data_a),
    .dp_valid_o(dpv_a), .dp_row_idx_o(idx_a), .dp_row_n_o(n_a), .dp_row_c_o(c_a), .dp_row_s_o(s_a),
    .dp_out_valid_i(dov_a), .dp_out_idx_i(doi_a), .dp_out_row_i(dor_a), .dp_out_cnt_i(dcnt_a));

  // DUT B: 3x3 grid, pass limit 2
  logic start_b, busy_b, done_b, rd_en_b, wr_en_b, dpv_b, dov_b;
  logic [14:0] first_b, total_b;
  logic [7:0]  pc_b, dcnt_b;
  logic [1:0]  rd_addr_b, wr_addr_b, idx_b, doi_b;
  logic [2:0]  rd_data_b, wr_data_b, n_b, c_b, s_b, dor_b;

  removal_pass_scheduler #(.WIDTH(3), .HEIGHT(3), .ROW_AW(2), .CNT_W(15), .MAX_PASSES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .first_pass_o(first_b), .total_removed_o(total_b), .pass_count_o(pc_b),
    .mem_rd_en_o(rd_en_b), .mem_rd_addr_o(rd_addr_b), .mem_rd_data_i(rd_data_b),
    .mem_wr_en_o(wr_en_b), .mem_wr_addr_o(wr_addr_b), .mem_wr_data_o(wr_data_b),
    .dp_valid_o(dpv_b), .dp_row_idx_o(idx_b), .dp_row_n_o(n_b), .dp_row_c_o(c_b), .dp_row_s_o(s_b),
    .dp_out_valid_i(dov_b), .dp_out_idx_i(doi_b), .dp_out_row_i(dor_b), .dp_out_cnt_i(dcnt_b));

  // Accessibility datapath: a roll with fewer than 4 rolled neighbours is removed.
  function automatic logic [15:0] dp_calc(input logic [7:0] n, input logic [7:0] c,
                                          input logic [7:0] s, input int w);
    logic [7:0] row;
    int cnt, nb, jj;
    row = c;
    cnt = 0;
    for (int j = 0; j < w; j++) begin
      if (c[j]) begin
        nb = 0;
        for (int dj = -1; dj <= 1; dj++) begin
          jj = j + dj;
          if (jj >= 0 && jj < w) begin
            nb += int'(n[jj]) + int'(s[jj]);
            if (dj != 0) nb += int'(c[jj]);
          end
        end
        if (nb < 4) begin
          row[j] = 1'b0;
          cnt++;
        end
      end
    end
    return {8'(cnt), row};
  endfunction

  // Banks (old data on same-address collision) and datapath delay lines
  logic [7:0] mem_a [HA];
  logic [7:0] ld_img_a [HA];
  logic       ld_a = 1'b0;
  logic [2:0] mem_b [3];
  logic [2:0] ld_img_b [3];
  logic       ld_b = 1'b0;
  int         lat_a = 1;

  logic       pa_v [8] = '{default: 1'b0};
  logic [2:0] pa_i [8];
  logic [7:0] pa_r [8];
  logic [7:0] pa_c [8];
  logic       pb_v [2] = '{default: 1'b0};
  logic [1:0] pb_i [2];
  logic [2:0] pb_r [2];
  logic [7:0] pb_c [2];

  always @(posedge clk) begin : p_env_a
    logic [15:0] r;
    if (ld_a) begin
      for (int k = 0; k < HA; k++) mem_a[k] <= ld_img_a[k];
    end else begin
      if (rd_en_a) rd_data_a <= (int'(rd_addr_a) < HA) ? mem_a[rd_addr_a] : 8'h00;
      if (wr_en_a && int'(wr_addr_a) < HA) mem_a[wr_addr_a] <= wr_data_a;
    end
    r = dp_calc(n_a, c_a, s_a, WA);
    pa_v[0] <= dpv_a; pa_i[0] <= idx_a; pa_r[0] <= r[7:0]; pa_c[0] <= r[15:8];
    for (int k = 1; k < 8; k++) begin
      pa_v[k] <= pa_v[k-1]; pa_i[k] <= pa_i[k-1]; pa_r[k] <= pa_r[k-1]; pa_c[k] <= pa_c[k-1];
    end
  end
  assign dov_a = pa_v[lat_a-1];
  assign doi_a = pa_i[lat_a-1];
  assign dor_a = pa_r[lat_a-1];
  assign dcnt_a = pa_c[lat_a-1];

  always @(posedge clk) begin : p_env_b
    logic [15:0] r;
    if (ld_b) begin
      for (int k = 0; k < 3; k++) mem_b[k] <= ld_img_b[k];
    end else begin
      if (rd_en_b) rd_data_b <= (int'(rd_addr_b) < 3) ? mem_b[rd_addr_b] : 3'b000;
      if (wr_en_b && int'(wr_addr_b) < 3) mem_b[wr_addr_b] <= wr_data_b;
    end
    r = dp_calc({5'b0, n_b}, {5'b0, c_b}, {5'b0, s_b}, 3);
    pb_v[0] <= dpv_b; pb_i[0] <= idx_b; pb_r[0] <= r[2:0]; pb_c[0] <= r[15:8];
    pb_v[1] <= pb_v[0]; pb_i[1] <= pb_i[0]; pb_r[1] <= pb_r[0]; pb_c[1] <= pb_c[0];
  end
  assign dov_b = pb_v[1];
  assign doi_b = pb_i[1];
  assign dor_b = pb_r[1];
  assign dcnt_b = pb_c[1];

  // Reference: whole-grid simultaneous removal passes with per-pass snapshots
  logic [7:0] snap [64][HA];
  logic [7:0] exp_grid [HA];
  int exp_first, exp_total, exp_passes;

  task automatic model_run(input int maxp);
    logic [7:0] g [HA];
    logic [7:0] nx [HA];
    int rem, pc, nb, rr, cc;
    for (int r = 0; r < HA; r++) g[r] = mem_a[r];
    pc = 0; exp_first = 0; exp_total = 0;
    forever begin
      if (pc < 64) for (int r = 0; r < HA; r++) snap[pc][r] = g[r];
      nx = g;
      rem = 0;
      for (int r = 0; r < HA; r++)
        for (int c = 0; c < WA; c++)
          if (g[r][c]) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr; cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < HA && cc >= 0 && cc < WA)
                  nb += int'(g[rr][cc]);
              end
            if (nb < 4) begin
              nx[r][c] = 1'b0;
              rem++;
            end
          end
      g = nx;
      pc++;
      if (pc == 1) exp_first = rem;
      exp_total += rem;
      if (rem == 0 || pc == maxp) break;
    end
    exp_passes = pc;
    exp_grid = g;
  endtask

  // Window contents, burst length and write order while DUT A is busy
  int mon_cnt, wr_seq, run_len;
  logic prev_v;
  always @(negedge clk) begin : p_mon
    int p, r;
    logic [7:0] en, ec, es;
    if (rst || !busy_a) begin
      mon_cnt = 0; wr_seq = 0; run_len = 0; prev_v = 1'b0;
    end else begin
      if (dpv_a) begin
        p = mon_cnt / HA;
        r = mon_cnt % HA;
        if (p > 63) p = 63;
        en = (r == 0) ? 8'h00 : snap[p][r-1];
        ec = snap[p][r];
        es = (r == HA - 1) ? 8'h00 : snap[p][r+1];
        chk("window", {idx_a, n_a, c_a, s_a}, {3'(r), en, ec, es});
        mon_cnt++;
        run_len++;
      end else if (prev_v) begin
        chk("burst_len", run_len, HA);
        run_len = 0;
      end
      prev_v = dpv_a;
      if (wr_en_a) begin
        chk("wr_addr", wr_addr_a, wr_seq % HA);
        wr_seq++;
      end
    end
  end

  task automatic load_a();
    @(negedge clk) ld_a = 1'b1;
    @(negedge clk) ld_a = 1'b0;
  endtask

  task automatic run_a(input int lat, input bit pulse);
    int cnt;
    lat_a = lat;
    model_run(255);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("accept", {busy_a, done_a, first_a, total_a, pc_a}, {1'b1, 1'b0, 15'd0, 15'd0, 8'd0});
    cnt = 0;
    while (!dpv_a && cnt < 20) begin @(negedge clk); cnt++; end
    chk("first_dp_delay", cnt, 3);
    if (pulse) begin
      cnt = 0;
      while (dpv_a && cnt < 100) begin @(negedge clk); cnt++; end
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
    end
    cnt = 0;
    while (!done_a && cnt < 20000) begin @(negedge clk); cnt++; end
    chk("done", done_a, 1'b1);
    chk("busy_low", busy_a, 1'b0);
    chk("first_pass", first_a, exp_first);
    chk("total", total_a, exp_total);
    chk("pass_count", pc_a, exp_passes);
    for (int r = 0; r < HA; r++) chk("bank_row", mem_a[r], exp_grid[r]);
  endtask

  function automatic logic [127:0] outs_a();
    return {busy_a, done_a, first_a, total_a, pc_a, rd_en_a, rd_addr_a, wr_en_a, wr_addr_a,
            wr_data_a, dpv_a, idx_a, n_a, c_a, s_a};
  endfunction

  initial begin : p_main
    int cnt;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_a(), '0);
    chk("reset_outs_b", {busy_b, done_b, rd_en_b, wr_en_b, dpv_b, pc_b}, '0);
    rst = 1'b0;

    // all-zero bank: a single zero pass
    for (int r = 0; r < HA; r++) ld_img_a[r] = 8'h00;
    load_a();
    run_a(1, 1'b0);
    chk("zero_first", first_a, 0);
    chk("zero_total", total_a, 0);
    chk("zero_passes", pc_a, 1);

    // 3x3 block of rolls bounded by empty cells: 4,4,1,0
    for (int r = 0; r < HA; r++) ld_img_a[r] = (r < 3) ? 8'h07 : 8'h00;
    load_a();
    run_a(5, 1'b0);
    chk("blk_first", first_a, 4);
    chk("blk_total", total_a, 9);
    chk("blk_passes", pc_a, 4);

    // 3x3 grid, pass limit 2: only the centre survives
    for (int r = 0; r < 3; r++) ld_img_b[r] = 3'b111;
    @(negedge clk) ld_b = 1'b1;
    @(negedge clk) begin ld_b = 1'b0; start_b = 1'b1; end
    @(negedge clk) start_b = 1'b0;
    cnt = 0;
    while (!done_b && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("lim_done", done_b, 1'b1);
    chk("lim_first", first_b, 4);
    chk("lim_total", total_b, 8);
    chk("lim_passes", pc_b, 2);
    chk("lim_bank", {mem_b[0], mem_b[1], mem_b[2]}, {3'b000, 3'b010, 3'b000});

    // random dense grids, random datapath latency, one run with a stray start
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < HA; r++) ld_img_a[r] = 8'($urandom | $urandom);
      load_a();
      run_a(int'($urandom_range(1, 8)), t == 2);
    end

    // reset during the second pass, then rerun from the partially updated bank
    for (int r = 0; r < HA; r++) ld_img_a[r] = 8'($urandom | $urandom);
    ld_img_a[0][0] = 1'b1;
    load_a();
    lat_a = 3;
    model_run(255);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cnt = 0;
    while (pc_a != 8'd1 && cnt < 2000) begin @(negedge clk); cnt++; end
    while (!dpv_a && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("reached_pass2", {pc_a, dpv_a}, {8'd1, 1'b1});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset", outs_a(), '0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_a(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : p_watchdog
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
